// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the slice-pipelined adder: default geometry and stage-count derivation.
package pipelined_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SLICE = 4;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// SLICE-bit combinational ripple-carry adder used by each pipeline stage.
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[SLICE];

endmodule

// File: rtl/pipelined_adder.sv
// Slice-pipelined adder with valid/ready handshake; one SLICE per stage, latency STAGES.
// Optional subtract mode enabled by defining PIPELINED_ADDER_SUB_EN (adds input port sub).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, SLICE);

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef PIPELINED_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; the beat's cin is ignored in that mode.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  assign in_ready = ~stall;

  // Stage k keeps only the operand bits still to be added (skew) and the sum bits finished so far (deskew).
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM = WIDTH - k * SLICE;

    logic [REM-1:0]       a_cur;
    logic [REM-1:0]       b_cur;
    logic                 c_cur;
    logic                 v_cur;
    logic [SLICE-1:0]     slice_sum;
    logic                 slice_cout;
    logic [(k+1)*SLICE-1:0] s_next;
    logic [(k+1)*SLICE-1:0] s_q;
    logic                 c_q;
    logic                 v_q;

    if (k == 0) begin : g_src
      assign a_cur  = a;
      assign b_cur  = b_eff;
      assign c_cur  = c_eff;
      assign v_cur  = in_valid;
      assign s_next = slice_sum;
    end else begin : g_src
      assign a_cur  = g_stage[k-1].g_ops.a_q;
      assign b_cur  = g_stage[k-1].g_ops.b_q;
      assign c_cur  = g_stage[k-1].c_q;
      assign v_cur  = g_stage[k-1].v_q;
      assign s_next = {slice_sum, g_stage[k-1].s_q};
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_cur[SLICE-1:0]),
      .b    (b_cur[SLICE-1:0]),
      .cin  (c_cur),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_cur;
        c_q <= slice_cout;
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-SLICE-1:0] a_q;
      logic [REM-SLICE-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_cur[REM-1:SLICE];
          b_q <= b_cur[REM-1:SLICE];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_cin;
      logic ovf_q;

      assign msb_cin = a_cur[SLICE-1] ^ b_cur[SLICE-1] ^ slice_sum[SLICE-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= msb_cin ^ slice_cout;
        end
      end

      assign stall     = v_q & ~out_ready;
      assign out_valid = v_q;
      assign sum       = s_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, SLICE=4): vector table, directed handshake cases, random scoreboard.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        cout;
  logic        ovf;
  logic [15:0] sum;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t        q[$];
  int unsigned pop_cycs[$];
  int unsigned passed = 0;
  int unsigned total = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned last_pop_cyc = 0;
  logic [17:0] last_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    int   r_u;
    int   r_s;
    exp_t e;
    if (s) begin
      r_u    = int'(x) - int'(y);
      r_s    = int'($signed(x)) - int'($signed(y));
      e.cout = (x >= y);
    end else begin
      r_u    = int'(x) + int'(y) + int'(c);
      r_s    = int'($signed(x)) + int'($signed(y)) + int'(c);
      e.cout = (r_u > 65535);
    end
    e.sum = r_u[15:0];
    e.ovf = (r_s > 32767) || (r_s < -32768);
    return e;
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("scoreboard", {14'd0, cout, ovf, sum}, {14'd0, e.cout, e.ovf, e.sum});
      end
      last_pop_cyc = cyc;
      last_out     = {cout, ovf, sum};
      pop_cycs.push_back(cyc);
      pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic single_beat(input string name, input logic [15:0] x, input logic [15:0] y,
                             input logic c, input logic s, input logic [17:0] exp_out);
    int unsigned p0;
    int unsigned acc;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    p0  = pops;
    acc = cyc;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < 10 && pops == p0; j++) step();
    check({name, "_count"}, pops - p0, 1);
    check({name, "_latency"}, last_pop_cyc - acc, 4);
    check({name, "_result"}, {14'd0, last_out}, {14'd0, exp_out});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vt[8];
    int unsigned p0;
    int unsigned bad_sum;
    int unsigned bad_ir;
    logic [15:0] held;

    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    #12;
    check("reset_outputs", {13'd0, out_valid, cout, ovf, sum}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      single_beat($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, 1'b0,
                  {vt[i].cout, vt[i].ovf, vt[i].sum});

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    p0 = pops;
    bad_ir = 0;
    pop_cycs.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      if (in_ready !== 1'b1) bad_ir++;
      step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 12 && pops < p0 + 8; j++) begin
      if (in_ready !== 1'b1) bad_ir++;
      step();
    end
    check("b2b_count", pops - p0, 8);
    check("b2b_in_ready_low", bad_ir, 0);
    check("b2b_consecutive", (pop_cycs.size() == 8) ? pop_cycs[7] - pop_cycs[0] : 32'hFFFF, 7);

    // Stall with results pending: outputs and input side frozen for six cycles.
    p0 = pops;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 10 && !out_valid; j++) step();
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    held = sum;
    bad_sum = 0;
    bad_ir = 0;
    a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (in_ready !== 1'b0) bad_ir++;
      step();
      if (sum !== held || out_valid !== 1'b1) bad_sum++;
    end
    check("stall_in_ready_high", bad_ir, 0);
    check("stall_sum_changed", bad_sum, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 20 && q.size() != 0; j++) step();
    check("stall_drain_count", pops - p0, 3);
    check("stall_drain_empty", q.size(), 0);

    // Reset with three beats in flight discards them.
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {13'd0, out_valid, cout, ovf, sum}, 32'd0);
    check("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    p0 = pops;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) step();
    check("reset_discard", pops - p0, 0);

`ifdef PIPELINED_ADDER_SUB_EN
    single_beat("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    single_beat("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
`endif

    // Random valid/ready traffic checked by the scoreboard.
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 40 && q.size() != 0; j++) step();
    check("random_drain_empty", q.size(), 0);
    check("random_activity", {31'd0, (pops - p0) > 50}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
